// File: rtl/iir_ctrl.sv
// Sequencing controller for an IIR filter: streams samples with an outstanding-count
// limit and swaps in a new coefficient set only once the filter pipeline has drained.
//
// state | meaning
// IDLE  | not streaming, waiting for EN or CFG_COMMIT
// RUN   | streaming samples while fewer than MAX_OUT are in flight
// DRAIN | commit pending, waiting for in-flight samples or the drain timeout
// LOAD  | one cycle: copy the shadow set to the active coefficients
// FLUSH | FILT_CLR held for FLUSH_CYC cycles, then back to IDLE
module iir_ctrl #(
    parameter int MAX_OUT   = 6,
    parameter int FLUSH_CYC = 2,
    parameter int DRAIN_TO  = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [8:0] S_DIN,
    input  logic       S_VIN,
    output logic       S_RDY,
    input  logic       CFG_WE,
    input  logic [1:0] CFG_ADDR,
    input  logic [8:0] CFG_DATA,
    input  logic       CFG_COMMIT,
    output logic       CFG_BUSY,
    output logic [8:0] DIN,
    output logic       VIN,
    output logic [8:0] A12,
    output logic [8:0] B0,
    output logic [8:0] B1A1,
    output logic [8:0] B1mB0A1,
    input  logic       VOUT,
    output logic       FILT_CLR,
    output logic       ERR
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, LOAD, FLUSH} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [7:0] drain_cnt;
    logic [3:0] flush_cnt;
    logic [8:0] shadow [4];
    logic       accept;
    logic       vout_err;

    assign S_RDY    = (state == RUN) && (cnt < 4'(MAX_OUT));
    assign CFG_BUSY = (state == DRAIN) || (state == LOAD) || (state == FLUSH);
    assign accept   = S_VIN && S_RDY;

    // A simultaneous accept and VOUT cancel out; a VOUT with nothing in flight is an error.
    always_comb begin
        cnt_nxt  = cnt;
        vout_err = 1'b0;
        if (accept && !VOUT) begin
            cnt_nxt = cnt + 4'd1;
        end else if (!accept && VOUT) begin
            if (cnt == 4'd0) vout_err = 1'b1;
            else             cnt_nxt  = cnt - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            drain_cnt <= 8'd0;
            flush_cnt <= 4'd0;
            VIN       <= 1'b0;
            DIN       <= 9'd0;
            A12       <= 9'd0;
            B0        <= 9'd0;
            B1A1      <= 9'd0;
            B1mB0A1   <= 9'd0;
            FILT_CLR  <= 1'b0;
            ERR       <= 1'b0;
            for (int i = 0; i < 4; i++) shadow[i] <= 9'd0;
        end else begin
            VIN <= accept;
            if (accept) DIN <= S_DIN;
            cnt <= cnt_nxt;
            if (vout_err) ERR <= 1'b1;
            if (CFG_WE) shadow[CFG_ADDR] <= CFG_DATA;

            case (state)
                IDLE: begin
                    if (CFG_COMMIT) begin
                        state     <= DRAIN;
                        drain_cnt <= 8'd0;
                    end else if (EN) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (CFG_COMMIT) begin
                        state     <= DRAIN;
                        drain_cnt <= 8'd0;
                    end else if (!EN) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 8'd1;
                    if (cnt == 4'd0 && !VIN) begin
                        state <= LOAD;
                    end else if (drain_cnt == 8'(DRAIN_TO - 1)) begin
                        state <= LOAD;
                        if (cnt != 4'd0) ERR <= 1'b1;
                    end
                end
                LOAD: begin
                    // Shadow values read here predate any same-cycle CFG_WE.
                    A12       <= shadow[0];
                    B0        <= shadow[1];
                    B1A1      <= shadow[2];
                    B1mB0A1   <= shadow[3];
                    cnt       <= 4'd0;
                    flush_cnt <= 4'(FLUSH_CYC - 1);
                    FILT_CLR  <= 1'b1;
                    state     <= FLUSH;
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        FILT_CLR <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_ctrl.sv
// Bench for iir_ctrl: streaming vector table, directed commit/timeout/reset sequences,
// and randomized traffic, all checked against a cycle-level behavioural model.
module tb_iir_ctrl;

    localparam int MAX_OUT   = 6;
    localparam int FLUSH_CYC = 2;
    localparam int DRAIN_TO  = 64;

    logic       CLK = 1'b0;
    logic       RST, EN, S_VIN, CFG_WE, CFG_COMMIT, VOUT;
    logic [8:0] S_DIN, CFG_DATA;
    logic [1:0] CFG_ADDR;
    logic       S_RDY, CFG_BUSY, VIN, FILT_CLR, ERR;
    logic [8:0] DIN, A12, B0, B1A1, B1mB0A1;

    int n_tests = 0;
    int n_fail  = 0;

    iir_ctrl #(.MAX_OUT(MAX_OUT), .FLUSH_CYC(FLUSH_CYC), .DRAIN_TO(DRAIN_TO)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .S_DIN(S_DIN), .S_VIN(S_VIN), .S_RDY(S_RDY),
        .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .CFG_COMMIT(CFG_COMMIT),
        .CFG_BUSY(CFG_BUSY), .DIN(DIN), .VIN(VIN), .A12(A12), .B0(B0), .B1A1(B1A1),
        .B1mB0A1(B1mB0A1), .VOUT(VOUT), .FILT_CLR(FILT_CLR), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: phase, samples in flight, elapsed drain cycles, remaining flush cycles.
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_LOAD = 3, P_FLUSH = 4;
    int m_ph, m_out, m_dcyc, m_fleft, m_din;
    bit m_err, m_vin;
    int m_sh [4];
    int m_act [4];

    task automatic model_step();
        int  n_ph, n_out;
        bit  acc;
        if (RST) begin
            m_ph = P_IDLE; m_out = 0; m_dcyc = 0; m_fleft = 0; m_din = 0;
            m_err = 0; m_vin = 0;
            for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end
            return;
        end
        acc   = S_VIN && (m_ph == P_RUN) && (m_out < MAX_OUT);
        n_out = m_out;
        if (acc && !VOUT) n_out = m_out + 1;
        else if (!acc && VOUT) begin
            if (m_out == 0) m_err = 1;
            else n_out = m_out - 1;
        end
        n_ph = m_ph;
        case (m_ph)
            P_IDLE, P_RUN: begin
                if (CFG_COMMIT) begin n_ph = P_DRAIN; m_dcyc = 0; end
                else if (m_ph == P_IDLE && EN) n_ph = P_RUN;
                else if (m_ph == P_RUN && !EN) n_ph = P_IDLE;
            end
            P_DRAIN: begin
                m_dcyc++;
                if (m_out == 0 && !m_vin) n_ph = P_LOAD;
                else if (m_dcyc == DRAIN_TO) begin
                    if (m_out > 0) m_err = 1;
                    n_ph = P_LOAD;
                end
            end
            P_LOAD: begin
                m_act   = m_sh;
                n_out   = 0;
                m_fleft = FLUSH_CYC;
                n_ph    = P_FLUSH;
            end
            default: begin
                m_fleft--;
                if (m_fleft == 0) n_ph = P_IDLE;
            end
        endcase
        if (CFG_WE) m_sh[CFG_ADDR] = int'(CFG_DATA);
        m_vin = acc;
        if (acc) m_din = int'(S_DIN);
        m_ph  = n_ph;
        m_out = n_out;
    endtask

    task automatic chk(string nm, logic [31:0] act, int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("mdl_s_rdy",   32'(S_RDY),    int'(m_ph == P_RUN && m_out < MAX_OUT));
        chk("mdl_vin",     32'(VIN),      int'(m_vin));
        chk("mdl_din",     32'(DIN),      m_din);
        chk("mdl_busy",    32'(CFG_BUSY), int'(m_ph == P_DRAIN || m_ph == P_LOAD || m_ph == P_FLUSH));
        chk("mdl_filt_clr",32'(FILT_CLR), int'(m_ph == P_FLUSH));
        chk("mdl_err",     32'(ERR),      int'(m_err));
        chk("mdl_a12",     32'(A12),      m_act[0]);
        chk("mdl_b0",      32'(B0),       m_act[1]);
        chk("mdl_b1a1",    32'(B1A1),     m_act[2]);
        chk("mdl_b1mb0a1", 32'(B1mB0A1),  m_act[3]);
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic drv(int rst, int en, int svin, int sdin, int vout,
                       int commit, int we, int addr, int data);
        RST = (rst != 0); EN = (en != 0); S_VIN = (svin != 0); S_DIN = 9'(sdin);
        VOUT = (vout != 0); CFG_COMMIT = (commit != 0); CFG_WE = (we != 0);
        CFG_ADDR = 2'(addr); CFG_DATA = 9'(data);
        tick();
    endtask

    task automatic idle_cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        int en, svin, sdin, vout;
        int exp_rdy, exp_vin, exp_din, exp_err;
    } vec_t;

    vec_t tbl [19];

    initial begin
        tbl[0]  = '{1, 0, 'h000, 0, 1, 0, 'h000, 0};
        tbl[1]  = '{1, 1, 'h0A5, 0, 1, 1, 'h0A5, 0};
        tbl[2]  = '{1, 1, 'h001, 0, 1, 1, 'h001, 0};
        tbl[3]  = '{1, 1, 'h002, 0, 1, 1, 'h002, 0};
        tbl[4]  = '{1, 1, 'h003, 0, 1, 1, 'h003, 0};
        tbl[5]  = '{1, 1, 'h004, 0, 1, 1, 'h004, 0};
        tbl[6]  = '{1, 1, 'h005, 0, 0, 1, 'h005, 0};
        tbl[7]  = '{1, 1, 'h006, 0, 0, 0, 'h005, 0};
        tbl[8]  = '{1, 0, 'h000, 1, 1, 0, 'h005, 0};
        tbl[9]  = '{1, 1, 'h007, 1, 1, 1, 'h007, 0};
        tbl[10] = '{1, 1, 'h008, 0, 0, 1, 'h008, 0};
        tbl[11] = '{0, 0, 'h000, 0, 0, 0, 'h008, 0};
        for (int i = 12; i < 18; i++) tbl[i] = '{0, 0, 'h000, 1, 0, 0, 'h008, 0};
        tbl[18] = '{0, 0, 'h000, 1, 0, 0, 'h008, 1};

        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 1, 'h1FF, 1, 1, 1, 2, 'h1FF);
        chk("rst_s_rdy", 32'(S_RDY), 0);
        chk("rst_busy",  32'(CFG_BUSY), 0);
        chk("rst_vin",   32'(VIN), 0);
        chk("rst_din",   32'(DIN), 0);
        chk("rst_b1a1",  32'(B1A1), 0);
        chk("rst_err",   32'(ERR), 0);
        idle_cyc();
        chk("rst_no_shadow", 32'(B1A1), 0);

        // Streaming and backpressure table
        for (int i = 0; i < 19; i++) begin
            drv(0, tbl[i].en, tbl[i].svin, tbl[i].sdin, tbl[i].vout, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_rdy", i), 32'(S_RDY), tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_vin", i), 32'(VIN),   tbl[i].exp_vin);
            chk($sformatf("tbl%0d_din", i), 32'(DIN),   tbl[i].exp_din);
            chk($sformatf("tbl%0d_err", i), 32'(ERR),   tbl[i].exp_err);
        end

        // Commit with two samples in flight
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 'h011);
        drv(0, 0, 0, 0, 0, 0, 1, 1, 'h022);
        drv(0, 0, 0, 0, 0, 0, 1, 2, 'h033);
        drv(0, 0, 0, 0, 0, 0, 1, 3, 'h044);
        chk("cm_pre_a12", 32'(A12), 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 'h010, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 'h011, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("cm_drain_busy", 32'(CFG_BUSY), 1);
        chk("cm_drain_rdy",  32'(S_RDY), 0);
        idle_cyc();
        chk("cm_wait_busy", 32'(CFG_BUSY), 1);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("cm_drain2_filt", 32'(FILT_CLR), 0);
        idle_cyc();
        chk("cm_load_filt", 32'(FILT_CLR), 0);
        chk("cm_load_a12",  32'(A12), 0);
        idle_cyc();
        chk("cm_flush1_filt", 32'(FILT_CLR), 1);
        chk("cm_a12",     32'(A12), 'h011);
        chk("cm_b0",      32'(B0), 'h022);
        chk("cm_b1a1",    32'(B1A1), 'h033);
        chk("cm_b1mb0a1", 32'(B1mB0A1), 'h044);
        idle_cyc();
        chk("cm_flush2_filt", 32'(FILT_CLR), 1);
        idle_cyc();
        chk("cm_done_filt", 32'(FILT_CLR), 0);
        chk("cm_done_busy", 32'(CFG_BUSY), 0);

        // Write during LOAD only reaches the shadow; commit while busy is dropped
        drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_cyc();
        drv(0, 0, 0, 0, 0, 0, 1, 1, 'h1FF);
        chk("ld_we_b0", 32'(B0), 'h022);
        drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_cyc();
        chk("busy_commit_busy", 32'(CFG_BUSY), 0);
        idle_cyc();
        chk("busy_commit_dropped", 32'(CFG_BUSY), 0);
        drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_cyc();
        idle_cyc();
        chk("ld2_b0",  32'(B0), 'h1FF);
        chk("ld2_a12", 32'(A12), 'h011);
        idle_cyc();
        idle_cyc();

        // Drain timeout with one sample never returned
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 'h055, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= DRAIN_TO; i++) begin
            idle_cyc();
            if (i == DRAIN_TO - 1) begin
                chk("to_err_early",  32'(ERR), 0);
                chk("to_busy_early", 32'(CFG_BUSY), 1);
            end
        end
        chk("to_err",       32'(ERR), 1);
        chk("to_load_filt", 32'(FILT_CLR), 0);
        idle_cyc();
        chk("to_flush_filt", 32'(FILT_CLR), 1);
        idle_cyc();
        idle_cyc();
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= MAX_OUT; i++) begin
            drv(0, 1, 1, i, 0, 0, 0, 0, 0);
            chk($sformatf("to_cnt_clr_rdy%0d", i), 32'(S_RDY), (i < MAX_OUT) ? 1 : 0);
        end

        // Reset during FLUSH
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 1, 0, 'h0AA);
        chk("mr_err_set", 32'(ERR), 1);
        drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_cyc();
        idle_cyc();
        chk("mr_flush_filt", 32'(FILT_CLR), 1);
        chk("mr_flush_a12",  32'(A12), 'h0AA);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_filt", 32'(FILT_CLR), 0);
        chk("mr_a12",  32'(A12), 0);
        chk("mr_busy", 32'(CFG_BUSY), 0);
        chk("mr_err",  32'(ERR), 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_idle_to_run", 32'(S_RDY), 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            drv(($urandom_range(0, 199) == 0) ? 1 : 0,
                ($urandom_range(0, 7) != 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 511)),
                (m_out > 0) ? (($urandom_range(0, 2) == 0) ? 1 : 0)
                            : (($urandom_range(0, 49) == 0) ? 1 : 0),
                ($urandom_range(0, 24) == 0) ? 1 : 0,
                ($urandom_range(0, 3) == 0) ? 1 : 0,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 511)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_ctrl.md
IIR_CTRL -- requirements
Module: iir_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have MAX_OUT, default 6: the maximum number of samples in flight inside the filter (range 1..15).
REQ-002 SHALL have FLUSH_CYC, default 2: the number of cycles FILT_CLR is held after a coefficient load (range 1..15).
REQ-003 SHALL have DRAIN_TO, default 64: the cycle limit for the DRAIN state before a forced load (range 1..255).

Ports (name, direction, width, meaning):
REQ-004 SHALL have the ports listed below.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- EN  in  1  enables sample streaming.
- S_DIN  in  9  upstream sample.
- S_VIN  in  1  upstream sample valid.
- S_RDY  out  1  controller accepts sample.
- CFG_WE  in  1  shadow coefficient write strobe.
- CFG_ADDR  in  2  coefficient select: 0=A12, 1=B0, 2=B1A1, 3=B1mB0A1.
- CFG_DATA  in  9  coefficient value.
- CFG_COMMIT  in  1  request to apply the shadow set.
- CFG_BUSY  out  1  commit in progress.
- DIN  out  9  sample to filter.
- VIN  out  1  sample valid to filter.
- A12, B0, B1A1, B1mB0A1  out  9 each  active coefficients to filter.
- VOUT  in  1  filter output valid.
- FILT_CLR  out  1  active-high filter state clear.
- ERR  out  1  sticky error flag.

Function
REQ-005 SHALL implement the FSM states IDLE, RUN, DRAIN, LOAD, FLUSH.
REQ-006 SHALL transition IDLE->RUN when EN=1 and CFG_COMMIT=0.
REQ-007 SHALL transition RUN->IDLE when EN=0.
REQ-008 SHALL transition IDLE or RUN->DRAIN when CFG_COMMIT=1; CFG_COMMIT SHALL take priority over EN.
REQ-009 SHALL transition DRAIN->LOAD when cnt=0 and VIN=0, or when the DRAIN cycle counter reaches DRAIN_TO.
REQ-010 SHALL transition LOAD->FLUSH after exactly one cycle.
REQ-011 SHALL transition FLUSH->IDLE after exactly FLUSH_CYC cycles.
REQ-012 SHALL drive S_RDY = (state=RUN) AND (cnt<MAX_OUT), combinationally from registered state.
REQ-013 SHALL register the upstream sample on acceptance (S_VIN AND S_RDY): DIN<=S_DIN and VIN<=1 on the next edge, giving 1-cycle latency; otherwise VIN<=0 and DIN holds its value.
REQ-014 SHALL hold a 4-bit outstanding counter cnt: +1 on acceptance, -1 on VOUT, unchanged when both occur in the same cycle.
REQ-015 SHALL treat VOUT while cnt=0 (with no acceptance that cycle) as an error: cnt stays 0 and ERR<=1.
REQ-016 SHALL write CFG_DATA into the shadow register selected by CFG_ADDR whenever CFG_WE=1, in any state.
REQ-017 SHALL, in LOAD, copy all four shadow registers to the active outputs in one edge, using shadow values as of the start of that cycle; a CFG_WE in the same cycle SHALL update only the shadow.
REQ-018 SHALL assert CFG_BUSY=1 in DRAIN, LOAD and FLUSH, and 0 otherwise.
REQ-019 SHALL ignore CFG_COMMIT while CFG_BUSY=1; commits are not queued.
REQ-020 SHALL assert FILT_CLR=1 only in FLUSH, and SHALL reset cnt to 0 on the LOAD->FLUSH edge.
REQ-021 SHALL, on DRAIN timeout (cnt>0 at DRAIN_TO), set ERR<=1 and force LOAD.
REQ-022 SHALL keep the active coefficients stable except on the LOAD edge.

Reset
REQ-023 SHALL, when RST=1 at a rising edge, set: state=IDLE, cnt=0, DRAIN counter=0, VIN=0, DIN=0, all shadow and active coefficients=0, FILT_CLR=0, ERR=0; S_RDY and CFG_BUSY SHALL then read 0.
REQ-024 SHALL give RST priority over all other inputs, including mid-DRAIN or mid-FLUSH; the commit in progress is abandoned and the coefficients revert to 0.
REQ-025 SHALL clear ERR only by reset.

Verification
REQ-026 SHALL cover basic streaming: RST, then EN=1, S_VIN=1 with S_DIN=0x0A5 -> VIN=1 with DIN=0x0A5 one cycle after acceptance; S_RDY=1 in RUN.
REQ-027 SHALL cover backpressure: accept 6 samples with no VOUT -> S_RDY=0 with cnt=6; one VOUT pulse -> S_RDY=1 on the next cycle.
REQ-028 SHALL cover commit: write A12=0x011, B0=0x022, B1A1=0x033, B1mB0A1=0x044, then pulse CFG_COMMIT with cnt=2 -> DRAIN until 2 VOUT pulses arrive, one LOAD cycle, outputs equal the written values, FILT_CLR high for 2 cycles, then IDLE, CFG_BUSY=0.
REQ-029 SHALL cover same-cycle write in LOAD: CFG_WE to B0=0x1FF during LOAD -> active B0 keeps the old shadow value; a following commit applies 0x1FF.
REQ-030 SHALL cover drain timeout: commit with cnt=1 and VOUT never asserted -> after 64 DRAIN cycles ERR=1 and LOAD occurs; simultaneous acceptance+VOUT leaves cnt unchanged.
REQ-031 SHALL cover mid-operation reset: RST during FLUSH -> next cycle FILT_CLR=0, all coefficients 0, state IDLE, ERR=0.
